// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types for the GCD requester.
//   GCD_W   - default operand/result width
//   state_t - requester FSM states (IDLE/ISSUE/WAIT/RESP)
//   pair_t  - operand pair {a,b} at the default width
package gcd_pkg;

   localparam int GCD_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [GCD_W-1:0] a;
      logic [GCD_W-1:0] b;
   } pair_t;

endpackage

// File: rtl/gcd_op_fifo.sv
// gcd_op_fifo: synchronous FIFO of operand-pair structs.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   push, wdata  - write request and entry (ignored while full)
//   pop, rdata   - read request and head entry (rdata shows the head without popping)
//   full, empty  - occupancy flags, derived from registered count
//   count        - current occupancy, 0..DEPTH
module gcd_op_fifo
   import gcd_pkg::*;
#(
   parameter type T     = pair_t,
   parameter int  DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  T                         wdata,
   input  logic                     pop,
   output T                         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr];

   // Pointers are AW bits wide, so wrap modulo DEPTH comes for free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; entries are only read once written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

endmodule

// File: rtl/gcd_initiator.sv
// gcd_initiator: requester end of the GCD req/busy/valid protocol.
// Buffers operand pairs from an upstream valid/ready stream, issues them one
// at a time to a GCD responder and returns each result downstream with the
// operands echoed. Pairs with a zero operand bypass the responder; a watchdog
// abandons requests the responder never answers.
// Ports:
//   clk_i, rst_i                     - clock, asynchronous active-high reset
//   in_valid_i/in_ready_o/in_a_i/in_b_i - upstream operand stream
//   req_o/op_a_o/op_b_o              - request pulse and operands to responder
//   busy_i/valid_i/result_val_i      - responder status and result
//   out_valid_o/out_ready_i          - downstream handshake
//   out_a_o/out_b_o/out_result_o/out_err_o - echoed operands, GCD, timeout flag
//   pending_o                        - FIFO occupancy
module gcd_initiator
   import gcd_pkg::*;
#(
   parameter int W           = GCD_W,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [W-1:0]             in_a_i,
   input  logic [W-1:0]             in_b_i,
   output logic                     req_o,
   output logic [W-1:0]             op_a_o,
   output logic [W-1:0]             op_b_o,
   input  logic                     busy_i,
   input  logic                     valid_i,
   input  logic [W-1:0]             result_val_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [W-1:0]             out_a_o,
   output logic [W-1:0]             out_b_o,
   output logic [W-1:0]             out_result_o,
   output logic                     out_err_o,
   output logic [$clog2(DEPTH):0]   pending_o
);

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } op_pair_t;

   localparam int WDW = $clog2(TIMEOUT_CYC) + 1;

   state_t          state;
   op_pair_t        in_pair;
   op_pair_t        head;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_pop;
   logic            head_zero;
   logic [WDW-1:0]  wd;

   assign in_pair.a  = in_a_i;
   assign in_pair.b  = in_b_i;
   assign in_ready_o = !fifo_full;

   gcd_op_fifo #(
      .T     (op_pair_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (in_valid_i),
      .wdata (in_pair),
      .pop   (fifo_pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (pending_o)
   );

   // A zero operand needs no responder, so it is popped even while busy_i.
   assign head_zero = (head.a == '0) || (head.b == '0);
   assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && (head_zero || !busy_i);

   // ISSUE lasts exactly one cycle, so the request pulse is the state itself.
   assign req_o       = (state == ST_ISSUE);
   assign out_valid_o = (state == ST_RESP);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= ST_IDLE;
         op_a_o       <= '0;
         op_b_o       <= '0;
         out_a_o      <= '0;
         out_b_o      <= '0;
         out_result_o <= '0;
         out_err_o    <= 1'b0;
         wd           <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fifo_pop) begin
                  if (head_zero) begin
                     // gcd(x,0) = x and gcd(0,0) = 0, both equal to a|b.
                     out_a_o      <= head.a;
                     out_b_o      <= head.b;
                     out_result_o <= head.a | head.b;
                     out_err_o    <= 1'b0;
                     state        <= ST_RESP;
                  end else begin
                     op_a_o <= head.a;
                     op_b_o <= head.b;
                     state  <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               // Responder answers no earlier than the cycle after req, so
               // valid_i here belongs to nothing we issued.
               wd    <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // valid_i is tested first so it beats a coincident timeout.
               if (valid_i) begin
                  out_a_o      <= op_a_o;
                  out_b_o      <= op_b_o;
                  out_result_o <= result_val_i;
                  out_err_o    <= 1'b0;
                  state        <= ST_RESP;
               end else if (wd == WDW'(TIMEOUT_CYC - 1)) begin
                  out_a_o      <= op_a_o;
                  out_b_o      <= op_b_o;
                  out_result_o <= '0;
                  out_err_o    <= 1'b1;
                  state        <= ST_RESP;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            ST_RESP: begin
               if (out_ready_i) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
